seq_multiplier: RTL and testbench

- Sequential 32x32 integer multiplier; the inverse operation to the datapath divider. Produces the full 64-bit product as HI/LO for the MUL/MULT instructions in the ALU.
- Uses radix-4 Booth recoding, one digit per clock. Signed or unsigned operation is selected per operation.
- Start/busy/done handshake so the control unit can stall while the multiply runs.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/booth_encoder.sv | 30 +++
 rtl/seq_multiplier.sv | 127 ++++++++++++
 tb/tb_seq_multiplier.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared multiplier/divider definitions: FSM state encoding, Booth digit
// select encoding and the default datapath width.
package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_sel_e;

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth recoder: a 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
// becomes a digit in {0, +M, +2M, -M, -2M}, reported as negate/double/zero flags.
module booth_encoder
    import mult_pkg::*;
(
    input  logic [2:0] window,
    output logic       neg,
    output logic       dbl,
    output logic       zero
);

    booth_sel_e sel;

    always_comb begin
        sel = ZERO;
        case (window)
            3'b000, 3'b111: sel = ZERO;
            3'b001, 3'b010: sel = POS1;
            3'b011:         sel = POS2;
            3'b100:         sel = NEG2;
            3'b101, 3'b110: sel = NEG1;
            default:        sel = ZERO;
        endcase
    end

    assign neg  = (sel == NEG1) || (sel == NEG2);
    assign dbl  = (sel == POS2) || (sel == NEG2);
    assign zero = (sel == ZERO);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, radix-4 Booth, one digit per clock.
// Full 2*WIDTH product on HI/LO with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; operands captured on acceptance
// RUN   | one Booth digit added and shifted per cycle, ITER cycles
// DONE  | done pulse for one cycle, start ignored
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int XW   = WIDTH + 2;
    localparam int AW   = WIDTH + 3;
    localparam int CW   = $clog2(ITER + 1);

    state_e          state;
    logic [XW-1:0]   mcand;
    logic [XW-1:0]   mplier;
    logic            guard;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            dig_neg;
    logic            dig_dbl;
    logic            dig_zero;
    logic [XW-1:0]   a_ext;
    logic [XW-1:0]   b_ext;
    logic [AW-1:0]   mag;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   acc_sum;
    logic [AW-1:0]   acc_sh;
    logic [XW-1:0]   mplier_sh;
    logic [2*WIDTH-1:0] product;

    booth_encoder u_booth_encoder (
        .window ({mplier[1:0], guard}),
        .neg    (dig_neg),
        .dbl    (dig_dbl),
        .zero   (dig_zero)
    );

    // Two extra bits let unsigned operands be treated as non-negative signed values.
    always_comb begin
        a_ext = is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
        b_ext = is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
    end

    always_comb begin
        mag       = dig_dbl ? {mcand, 1'b0} : {mcand[XW-1], mcand};
        addend    = '0;
        if (!dig_zero) begin
            addend = dig_neg ? (~mag + AW'(1)) : mag;
        end
        acc_sum   = acc + addend;
        acc_sh    = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        mplier_sh = {acc_sum[1:0], mplier[XW-1:2]};
        // After ITER shifts the multiplier register holds the low XW product bits.
        product   = {acc_sh[WIDTH-3:0], mplier_sh};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            guard  <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a_ext;
                        mplier <= b_ext;
                        guard  <= 1'b0;
                        acc    <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_sh;
                    mplier <= mplier_sh;
                    guard  <= mplier[1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        HI    <= product[2*WIDTH-1:WIDTH];
                        LO    <= product[WIDTH-1:0];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: cycle-level reference model compared
// every cycle, directed corner cases and randomized back-to-back operations.
module tb_seq_multiplier;

    localparam int NRAND = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .HI        (HI),
        .LO        (LO)
    );

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
        logic [63:0] ae;
        logic [63:0] be;
        ae = s ? {{32{a[31]}}, a} : {32'b0, a};
        be = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ae * be;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference timeline: t = -1 idle, 0..16 busy, 17 done cycle.
    int          t;
    logic [63:0] pend;
    logic [63:0] expp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t    <= -1;
            pend <= '0;
            expp <= '0;
        end else if (t < 0) begin
            if (start) begin
                t    <= 0;
                pend <= golden(A, B, is_signed);
            end
        end else if (t == 16) begin
            t    <= 17;
            expp <= pend;
        end else if (t == 17) begin
            t <= -1;
        end else begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", {63'b0, busy}, {63'b0, (t >= 0 && t <= 16)});
        chk("cyc_done", {63'b0, done}, {63'b0, (t == 17)});
        chk("cyc_hilo", {HI, LO}, expp);
    end

    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        chk({"model_", nm}, golden(a, b, s), {ehi, elo});
        @(posedge clk); #1;
        A = a; B = b; is_signed = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; is_signed = ~s;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({"lat_", nm}, 64'(n), 64'd17);
        chk({"hi_", nm}, {32'b0, HI}, {32'b0, ehi});
        chk({"lo_", nm}, {32'b0, LO}, {32'b0, elo});
    endtask

    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                 32'h7FFFFFFF, 32'h00000002};

    initial begin
        int dones;
        int accepted;
        int guard_cnt;
        logic prev_busy;

        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("u7x6",     32'd7,        32'd6,        1'b0, 32'h0,        32'h2A);
        run_op("s_m3x5",   32'hFFFFFFFD, 32'd5,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("u_m3x5",   32'hFFFFFFFD, 32'd5,        1'b0, 32'h4,        32'hFFFFFFF1);
        run_op("u_max",    32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1);
        run_op("s_minmin", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h0);
        run_op("s_minm1",  32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h80000000);
        run_op("zero",     32'h0,        32'hDEADBEEF, 1'b1, 32'h0,        32'h0);

        // Second start during RUN plus operand changes must be ignored.
        @(posedge clk); #1;
        A = 32'd3; B = 32'd4; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (cyc == 5) begin A = 32'd9; B = 32'd9; start = 1'b1; end
            if (cyc > 5 && cyc < 10) begin A = $urandom; B = $urandom; end
            if (cyc == 10) start = 1'b0;
        end
        chk("ignore_dones", 64'(dones), 64'd1);
        chk("ignore_hilo", {HI, LO}, 64'd12);

        // Asynchronous reset mid-operation.
        @(posedge clk); #1;
        A = 32'h1234; B = 32'h5678; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        chk("abort_dones", 64'(dones), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op("after_rst", 32'd2, 32'd3, 1'b0, 32'h0, 32'h6);

        // Randomized back-to-back: start held high, operands churn every cycle.
        accepted  = 0;
        guard_cnt = 0;
        prev_busy = busy;
        @(posedge clk); #1;
        start = 1'b1;
        while (accepted < NRAND && guard_cnt < 60000) begin
            if ($urandom_range(0, 7) == 0) A = corners[$urandom_range(0, 5)];
            else A = $urandom;
            if ($urandom_range(0, 7) == 0) B = corners[$urandom_range(0, 5)];
            else B = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard_cnt++;
            if (busy && !prev_busy) accepted++;
            prev_busy = busy;
        end
        start = 1'b0;
        chk("rand_accepted", 64'(accepted), 64'(NRAND));
        repeat (25) @(posedge clk);
        #1;
        chk("final_idle", {63'b0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
